mmio_ctrl: RTL and testbench

Memory-mapped I/O controller for the 3-stage RISC-V core. It decodes the execute-stage ALU address for loads and stores in the 0x8000_00xx I/O window and owns the UART ready/valid handshakes and the cycle and instruction counters. It also owns a one-deep UART transmit buffer. It returns a registered 32-bit read value that the writeback stage selects via its UART_CONTROL, UART_RECEIVER, CYC_COUNTER and INST_COUNTER writeback-select codes.

---
 rtl/mmio_ctrl_pkg.sv | 15 +
 rtl/mmio_counter.sv | 22 ++
 rtl/mmio_ctrl.sv | 140 ++++++++++++++
 tb/tb_mmio_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_ctrl_pkg.sv
// Shared address map and control-register bit positions for mmio_ctrl.
// Offsets are the low byte of the 0x8000_00xx window.
package mmio_ctrl_pkg;
  localparam logic [3:0] IO_REGION          = 4'h8;
  localparam logic [7:0] UART_CONTROL_ADDR  = 8'h00;
  localparam logic [7:0] UART_RECEIVER_ADDR = 8'h04;
  localparam logic [7:0] UART_TRANSMIT_ADDR = 8'h08;
  localparam logic [7:0] CYC_COUNTER_ADDR   = 8'h10;
  localparam logic [7:0] INST_COUNTER_ADDR  = 8'h14;
  localparam logic [7:0] COUNTER_RESET_ADDR = 8'h18;
  localparam logic [7:0] BR_COUNTER_ADDR    = 8'h1C;
  localparam logic [7:0] BR_CORRECT_ADDR    = 8'h20;
  localparam int CTRL_TX_READY_BIT = 0;
  localparam int CTRL_RX_VALID_BIT = 1;
endpackage

// File: rtl/mmio_counter.sv
// Free-running W_SIZE-bit event counter; clear wins over increment.
module mmio_counter #(
  parameter int W_SIZE = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [W_SIZE-1:0] o_q
);
  logic [W_SIZE-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: UART handshakes, TX buffer, perf counters.
// MMIO_BRANCH_COUNTERS_EN adds branch counters at 0x1C / 0x20.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_SIZE-1:0] Addr,
  input  logic [W_SIZE-1:0] wdata,
  input  logic              load,
  input  logic              store,
  input  logic              flush,
  input  logic              inst_retire,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic              br_inst,
  input  logic              br_correct,
  output logic [W_SIZE-1:0] mmio_rdata
);
  logic              w_hit;
  logic [7:0]        w_off;
  logic              w_fire;
  logic              w_drain;
  logic              w_tx_wr;
  logic              w_clr;
  logic [1:0]        w_ctrl;
  logic [W_SIZE-1:0] w_rdata;
  logic [W_SIZE-1:0] w_cyc;
  logic [W_SIZE-1:0] w_inst;
  logic              w_unused;

  logic              r_tx_full;
  logic [7:0]        r_tx_data;
  logic [W_SIZE-1:0] r_rdata;

  assign w_hit   = (Addr[W_SIZE-1 -: 4] == IO_REGION);
  assign w_off   = Addr[7:0];
  assign w_fire  = (load | store) & ~flush;
  assign w_drain = r_tx_full & uart_tx_ready;
  assign w_tx_wr = w_fire & store & w_hit & (w_off == UART_TRANSMIT_ADDR);
  assign w_clr   = w_fire & store & w_hit & (w_off == COUNTER_RESET_ADDR);

  assign uart_rx_ready = ~rst & w_fire & load & w_hit
                       & (w_off == UART_RECEIVER_ADDR) & uart_rx_valid;

  assign w_unused = ^{Addr[W_SIZE-5:8], wdata[W_SIZE-1:8],
                      br_inst, br_correct};

  mmio_counter #(.W_SIZE(W_SIZE)) u_cyc_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (1'b1),
    .o_q   (w_cyc)
  );

  mmio_counter #(.W_SIZE(W_SIZE)) u_inst_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (inst_retire),
    .o_q   (w_inst)
  );

`ifdef MMIO_BRANCH_COUNTERS_EN
  logic [W_SIZE-1:0] w_br;
  logic [W_SIZE-1:0] w_brc;

  mmio_counter #(.W_SIZE(W_SIZE)) u_br_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (br_inst),
    .o_q   (w_br)
  );

  mmio_counter #(.W_SIZE(W_SIZE)) u_brc_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_clr),
    .i_inc (br_inst & br_correct),
    .o_q   (w_brc)
  );
`endif

  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_RX_VALID_BIT] = uart_rx_valid;
    w_ctrl[CTRL_TX_READY_BIT] = ~r_tx_full;
  end

  // Registered regardless of flush; writeback ignores squashed reads.
  always_comb begin
    w_rdata = '0;
    if (load && w_hit) begin
      unique case (1'b1)
        (w_off == UART_CONTROL_ADDR):  w_rdata = W_SIZE'(w_ctrl);
        (w_off == UART_RECEIVER_ADDR):
          w_rdata = {{(W_SIZE-8){1'b0}}, uart_rx_data};
        (w_off == CYC_COUNTER_ADDR):   w_rdata = w_cyc;
        (w_off == INST_COUNTER_ADDR):  w_rdata = w_inst;
`ifdef MMIO_BRANCH_COUNTERS_EN
        (w_off == BR_COUNTER_ADDR):    w_rdata = w_br;
        (w_off == BR_CORRECT_ADDR):    w_rdata = w_brc;
`endif
        default:                       w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_full <= 1'b0;
      r_tx_data <= '0;
    end else if (w_tx_wr && (!r_tx_full || w_drain)) begin
      r_tx_full <= 1'b1;
      r_tx_data <= wdata[7:0];
    end else if (w_drain) begin
      r_tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign uart_tx_valid = r_tx_full;
  assign uart_tx_data  = r_tx_data;
  assign mmio_rdata    = r_rdata;
endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed + random bench for mmio_ctrl against a cycle-level model.
// Define MMIO_BRANCH_COUNTERS_EN to match a DUT built with it.
module tb_mmio_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Addr;
  logic [31:0] wdata;
  logic        load;
  logic        store;
  logic        flush;
  logic        inst_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        br_inst;
  logic        br_correct;
  logic [31:0] mmio_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_cyc, m_inst, m_br, m_brc;
  logic        m_full;
  logic [7:0]  m_txd;

  logic [31:0] addrs [10] = '{
    32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0010,
    32'h8000_0014, 32'h8000_0018, 32'h8000_001C, 32'h8000_0020,
    32'h8000_0030, 32'h0000_0010
  };

  always #5 clk = ~clk;

  mmio_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .Addr          (Addr),
    .wdata         (wdata),
    .load          (load),
    .store         (store),
    .flush         (flush),
    .inst_retire   (inst_retire),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .br_inst       (br_inst),
    .br_correct    (br_correct),
    .mmio_rdata    (mmio_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic ld, input logic st, input logic fl,
                     input logic [31:0] a, input logic [31:0] wd);
    load  = ld;
    store = st;
    flush = fl;
    Addr  = a;
    wdata = wd;
  endtask

  task automatic idle();
    set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One clock: check the pop strobe, advance the model, check registers.
  task automatic step();
    logic        hit, fire, drain, rxr;
    logic [7:0]  off;
    logic [31:0] rd;
    #1;
    hit   = (Addr[31:28] == 4'h8);
    off   = Addr[7:0];
    fire  = (load | store) & ~flush;
    drain = m_full & uart_tx_ready;
    rxr   = ~rst & fire & load & hit & (off == 8'h04) & uart_rx_valid;
    chk("rx_ready", {31'b0, uart_rx_ready}, {31'b0, rxr});
    rd = 0;
    if (load && hit) begin
      case (off)
        8'h00: rd = {30'b0, uart_rx_valid, ~m_full};
        8'h04: rd = {24'b0, uart_rx_data};
        8'h10: rd = m_cyc;
        8'h14: rd = m_inst;
`ifdef MMIO_BRANCH_COUNTERS_EN
        8'h1C: rd = m_br;
        8'h20: rd = m_brc;
`endif
        default: rd = 0;
      endcase
    end
    if (rst) begin
      rd = 0; m_cyc = 0; m_inst = 0; m_br = 0; m_brc = 0;
      m_full = 0; m_txd = 0;
    end else begin
      if (fire && store && hit && off == 8'h08 && (!m_full || drain)) begin
        m_full = 1;
        m_txd  = wdata[7:0];
      end else if (drain) begin
        m_full = 0;
      end
      if (fire && store && hit && off == 8'h18) begin
        m_cyc = 0; m_inst = 0; m_br = 0; m_brc = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_inst = m_inst + 32'(inst_retire);
        m_br   = m_br + 32'(br_inst);
        m_brc  = m_brc + 32'(br_inst & br_correct);
      end
    end
    @(posedge clk);
    #1;
    chk("rdata", mmio_rdata, rd);
    chk("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_full});
    chk("tx_data", {24'b0, uart_tx_data}, {24'b0, m_txd});
  endtask

  initial begin
    m_cyc = 0; m_inst = 0; m_br = 0; m_brc = 0; m_full = 0; m_txd = 0;
    rst = 1'b1;
    inst_retire = 0; uart_rx_data = 8'h77; uart_rx_valid = 1'b1;
    uart_tx_ready = 0; br_inst = 0; br_correct = 0;
    set(1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0);
    step();
    set(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h55);
    step();
    chk("rst_rdata", mmio_rdata, 32'h0);
    chk("rst_txv", {31'b0, uart_tx_valid}, 32'h0);
    rst = 1'b0;
    uart_rx_valid = 1'b0;
    idle();
    repeat (10) step();
    set(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0);
    step();
    chk("cyc10", mmio_rdata, 32'd10);
    set(1'b1, 1'b0, 1'b0, 32'h8000_0014, 32'h0);
    step();
    chk("inst0", mmio_rdata, 32'd0);

    idle();
    while (m_cyc != 50) step();
    set(1'b0, 1'b1, 1'b0, 32'h8000_0018, 32'hFFFF);
    step();
    set(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0);
    step();
    chk("clr_cyc", mmio_rdata, 32'd0);
    set(1'b1, 1'b0, 1'b0, 32'h8000_0014, 32'h0);
    step();
    chk("clr_inst", mmio_rdata, 32'd0);

    force dut.u_inst_cnt.r_q = 32'hFFFF_FFFF;
    m_inst = 32'hFFFF_FFFF;
    idle();
    step();
    release dut.u_inst_cnt.r_q;
    inst_retire = 1;
    step();
    inst_retire = 0;
    set(1'b1, 1'b0, 1'b0, 32'h8000_0014, 32'h0);
    step();
    chk("wrap", mmio_rdata, 32'd0);

    set(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h41);
    step();
    chk("tx41", {24'b0, uart_tx_data}, 32'h41);
    set(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0);
    step();
    chk("ctrl_full", mmio_rdata, 32'h0);
    set(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h42);
    step();
    chk("tx_drop", {24'b0, uart_tx_data}, 32'h41);
    uart_tx_ready = 1;
    idle();
    step();
    chk("tx_drain", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 0;
    set(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h42);
    step();
    uart_tx_ready = 1;
    set(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h43);
    step();
    chk("tx43", {23'b0, uart_tx_valid, uart_tx_data}, 32'h143);

    for (int i = 0; i < 4; i++) begin
      uart_tx_ready = i[0];
      uart_rx_valid = i[1];
      set(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0);
      step();
    end
    uart_tx_ready = 0;

    uart_rx_valid = 1; uart_rx_data = 8'h5A;
    set(1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0);
    step();
    chk("rx5A", mmio_rdata, 32'h5A);
    set(1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h0);
    step();
    uart_rx_valid = 0;
    set(1'b1, 1'b0, 1'b0, 32'h8000_0030, 32'h0);
    step();
    chk("unmapped", mmio_rdata, 32'h0);

    set(1'b0, 1'b1, 1'b0, 32'h8000_0018, 32'h0);
    step();
    idle();
    br_inst = 1; br_correct = 1; step();
    br_correct = 0; step();
    br_correct = 1; step();
    br_inst = 0; br_correct = 0;
    set(1'b1, 1'b0, 1'b0, 32'h8000_001C, 32'h0);
    step();
`ifdef MMIO_BRANCH_COUNTERS_EN
    chk("br_cnt", mmio_rdata, 32'd3);
`else
    chk("br_cnt", mmio_rdata, 32'd0);
`endif
    set(1'b1, 1'b0, 1'b0, 32'h8000_0020, 32'h0);
    step();
`ifdef MMIO_BRANCH_COUNTERS_EN
    chk("br_ok", mmio_rdata, 32'd2);
`else
    chk("br_ok", mmio_rdata, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      set(op < 6, (op >= 6) && (op < 11), $urandom_range(0, 7) == 0,
          addrs[$urandom_range(0, 9)], $urandom);
      inst_retire   = 1'($urandom);
      uart_rx_valid = 1'($urandom);
      uart_rx_data  = 8'($urandom);
      uart_tx_ready = $urandom_range(0, 3) == 0;
      br_inst       = 1'($urandom);
      br_correct    = 1'($urandom);
      rst           = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
